// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the single-transaction I2C register master.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR_W,
    S_ACK1,
    S_REG,
    S_ACK2,
    S_WDATA,
    S_ACK3,
    S_RSTART,
    S_ADDR_R,
    S_ACK4,
    S_RDATA,
    S_MNACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic int calc_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

  // Ack slot that follows each byte-shifting state.
  function automatic state_t ack_state(input state_t s);
    case (s)
      S_ADDR_W: return S_ACK1;
      S_REG:    return S_ACK2;
      S_WDATA:  return S_ACK3;
      S_ADDR_R: return S_ACK4;
      default:  return S_MNACK;
    endcase
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Request/response bundle between on-chip logic and the I2C master controller.
interface i2c_master_ctrl_if;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;

  modport master (
    output start, rw, dev_addr, reg_addr, wr_data,
    input  busy, done, ack_err, rd_data
  );

  modport slave (
    input  start, rw, dev_addr, reg_addr, wr_data,
    output busy, done, ack_err, rd_data
  );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit divider: one-cycle tick every DIV clocks while enabled.
// The counter is forced to zero whenever the enable is low.
module i2c_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/i2c_master_ctrl.sv
// Single register write/read I2C master on open-drain SCL/SDA; one bit = 4 ticks.
// Busy from the cycle after start until done; start is only honoured in IDLE.
module i2c_master_ctrl
  import i2c_master_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  i2c_master_ctrl_if.slave    req,
  output wire                 i2c_scl,
  inout  wire                 i2c_sda
);
  localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sample_q, sample_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;

  logic busy;
  logic tick;
  logic sda_in;

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign sda_in = i2c_sda;

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;

    if (state_q == S_IDLE) begin
      if (req.start) begin
        rw_d      = req.rw;
        dev_d     = req.dev_addr;
        reg_d     = req.reg_addr;
        wdata_d   = req.wr_data;
        err_d     = 1'b0;
        phase_d   = PH0;
        bit_cnt_d = '0;
        state_d   = S_START;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
      case (phase_q)
        PH0: begin
          case (state_q)
            S_START, S_RSTART:                    sda_low_d = 1'b0;
            S_STOP:                               sda_low_d = 1'b1;
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R:   sda_low_d = ~shift_q[7];
            default:                              sda_low_d = 1'b0;
          endcase
        end
        PH1: scl_low_d = 1'b0;
        PH2: begin
          sample_d = sda_in;
          // START/STOP edges are the only SDA moves made while SCL is high.
          if (state_q == S_START || state_q == S_RSTART) sda_low_d = 1'b1;
          if (state_q == S_STOP)                         sda_low_d = 1'b0;
        end
        PH3: begin
          if (state_q != S_STOP) scl_low_d = 1'b1;
          case (state_q)
            S_START: begin
              state_d   = S_ADDR_W;
              shift_d   = {dev_q, RW_WRITE};
              bit_cnt_d = '0;
            end
            S_RSTART: begin
              state_d   = S_ADDR_R;
              shift_d   = {dev_q, RW_READ};
              bit_cnt_d = '0;
            end
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA: begin
              shift_d   = {shift_q[6:0], sample_q};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = ack_state(state_q);
            end
            S_ACK1, S_ACK2, S_ACK3, S_ACK4: begin
              bit_cnt_d = '0;
              if (sample_q) begin
                err_d   = 1'b1;
                state_d = S_STOP;
              end else begin
                case (state_q)
                  S_ACK1: begin
                    state_d = S_REG;
                    shift_d = reg_q;
                  end
                  S_ACK2: begin
                    if (rw_q == RW_READ) begin
                      state_d = S_RSTART;
                    end else begin
                      state_d = S_WDATA;
                      shift_d = wdata_q;
                    end
                  end
                  S_ACK3:  state_d = S_STOP;
                  default: state_d = S_RDATA;
                endcase
              end
            end
            S_MNACK: state_d = S_STOP;
            S_STOP: begin
              state_d = S_DONE;
              // The received byte stays in the shifter through MNACK and STOP.
              if ((rw_q == RW_READ) && !err_q) rd_data_d = shift_q;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sample_q  <= 1'b1;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rw_q      <= RW_WRITE;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
    end
  end

  assign req.busy    = busy;
  assign req.done    = (state_q == S_DONE);
  assign req.ack_err = err_q;
  assign req.rd_data = rd_data_q;

  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: open-drain bus with pull-ups, behavioural slave at 0x3C
// holding two registers, and a transaction-level model of the expected bus trace.
module tb_i2c_master_ctrl;
  localparam logic [6:0]  SLV_ADDR  = 7'h3C;
  localparam logic [15:0] SYM_START = 16'h1000;
  localparam logic [15:0] SYM_STOP  = 16'h2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire scl_w;
  wire sda_w;
  pullup (scl_w);
  pullup (sda_w);

  logic slv_low = 1'b0;
  assign sda_w = slv_low ? 1'b0 : 1'bz;

  i2c_master_ctrl_if req();

  i2c_master_ctrl #(
    .CLK_FREQ (4_000_000),
    .I2C_FREQ (1_000_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i2c_scl (scl_w),
    .i2c_sda (sda_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave plus bus monitor; trace holds START/STOP and {ackbit, byte}.
  logic [7:0]  sregs [2] = '{8'h5A, 8'h00};
  logic [15:0] trace [$];
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  int          bitn = 0;
  int          byte_i = 0;
  logic [7:0]  sh = '0;
  logic [7:0]  tx = '0;
  logic [7:0]  cur_reg = '0;
  bit          active = 0, tx_mode = 0, pend_tx = 0, rd_addr = 0, s_ack = 0;

  always @(scl_w or sda_w) begin
    if (scl_w !== scl_p) begin
      if (scl_w === 1'b1) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda_w};
          bitn++;
        end else begin
          trace.push_back({7'd0, sda_w, sh});
          bitn = 0;
        end
      end else if (active) begin
        if (bitn == 8) begin
          if (tx_mode) begin
            slv_low = 1'b0;
            tx_mode = 0;
          end else begin
            s_ack = 0;
            if (byte_i == 0) begin
              s_ack   = (sh[7:1] == SLV_ADDR);
              rd_addr = sh[0];
              pend_tx = s_ack && sh[0];
            end else if (byte_i == 1 && !rd_addr) begin
              s_ack   = (sh < 8'd2);
              cur_reg = sh;
            end else if (!rd_addr) begin
              s_ack = 1;
              sregs[cur_reg[0]] = sh;
            end
            slv_low = s_ack;
            if (!s_ack) active = 0;
            byte_i++;
          end
        end else if (bitn == 0) begin
          if (pend_tx) begin
            pend_tx = 0;
            tx_mode = 1;
            tx      = sregs[cur_reg[0]];
            slv_low = ~tx[7];
          end else begin
            slv_low = 1'b0;
          end
        end else if (tx_mode) begin
          slv_low = ~tx[7 - bitn];
        end
      end else begin
        slv_low = 1'b0;
      end
    end else if ((sda_w !== sda_p) && (scl_w === 1'b1)) begin
      if (sda_w === 1'b0) begin
        trace.push_back(SYM_START);
        active = 1;
        bitn = 0;
        byte_i = 0;
      end else begin
        trace.push_back(SYM_STOP);
        active = 0;
      end
      tx_mode = 0;
      pend_tx = 0;
      slv_low = 1'b0;
    end
    scl_p = scl_w;
    sda_p = sda_w;
  end

  // Transaction-level reference: expected bus symbols, flags and duration.
  logic [7:0]  m_regs [2] = '{8'h5A, 8'h00};
  logic [15:0] exp_q [$];
  logic        m_err = 1'b0;
  logic [7:0]  m_rd = 8'h00;
  int          m_ticks = 0;

  function automatic logic [15:0] bsym(input logic [7:0] b, input logic nack);
    return {7'd0, nack, b};
  endfunction

  task automatic model(input logic rw_v, input logic [6:0] dv, input logic [7:0] rg,
                       input logic [7:0] wd);
    exp_q.delete();
    m_err = 1'b0;
    exp_q.push_back(SYM_START);
    if (dv != SLV_ADDR) begin
      exp_q.push_back(bsym({dv, 1'b0}, 1'b1));
      m_err = 1'b1;
    end else begin
      exp_q.push_back(bsym({dv, 1'b0}, 1'b0));
      if (rg >= 8'd2) begin
        exp_q.push_back(bsym(rg, 1'b1));
        m_err = 1'b1;
      end else if (!rw_v) begin
        exp_q.push_back(bsym(rg, 1'b0));
        exp_q.push_back(bsym(wd, 1'b0));
        m_regs[rg[0]] = wd;
      end else begin
        exp_q.push_back(bsym(rg, 1'b0));
        exp_q.push_back(SYM_START);
        exp_q.push_back(bsym({dv, 1'b1}, 1'b0));
        exp_q.push_back(bsym(m_regs[rg[0]], 1'b1));
        m_rd = m_regs[rg[0]];
      end
    end
    exp_q.push_back(SYM_STOP);
    m_ticks = 0;
    foreach (exp_q[i]) m_ticks += (exp_q[i] == SYM_START || exp_q[i] == SYM_STOP) ? 4 : 36;
  endtask

  task automatic do_txn(input logic rw_v, input logic [6:0] dv, input logic [7:0] rg,
                        input logic [7:0] wd, input bit poke);
    int cyc;
    int base;
    int extra;
    bit seen;
    model(rw_v, dv, rg, wd);
    base = trace.size();
    @(negedge clk);
    req.start = 1'b1; req.rw = rw_v; req.dev_addr = dv; req.reg_addr = rg; req.wr_data = wd;
    @(negedge clk);
    req.start = 1'b0; req.rw = ~rw_v; req.dev_addr = ~dv; req.reg_addr = ~rg; req.wr_data = ~wd;
    chk("busy_rise", req.busy, 1);
    chk("done_early", req.done, 0);
    cyc = 1;
    seen = 0;
    for (int g = 0; g < 1000 && !seen; g++) begin
      @(negedge clk);
      req.start = 1'b0;
      if (req.done === 1'b1) seen = 1;
      else begin
        if (req.busy === 1'b1) cyc++;
        if (poke && cyc == 10) req.start = 1'b1;
      end
    end
    chk("done_seen", seen, 1);
    chk("ticks", cyc, m_ticks);
    chk("busy_in_done", req.busy, 0);
    chk("ack_err", req.ack_err, m_err);
    chk("rd_data", req.rd_data, m_rd);
    chk("trace_len", trace.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && (base + i) < trace.size(); i++)
      chk("trace_sym", trace[base + i], exp_q[i]);
    chk("sreg0", sregs[0], m_regs[0]);
    chk("sreg1", sregs[1], m_regs[1]);
    if (poke) req.start = 1'b1;
    @(negedge clk);
    req.start = 1'b0;
    chk("done_one_cycle", req.done, 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (req.busy === 1'b1 || req.done === 1'b1) extra++;
    end
    chk("no_extra_txn", extra, 0);
    chk("bus_quiet", trace.size() - base, exp_q.size());
    chk("hold_err", req.ack_err, m_err);
    chk("hold_rd", req.rd_data, m_rd);
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, "_scl"}, scl_w, 1);
    chk({tag, "_sda"}, sda_w, 1);
    chk({tag, "_busy"}, req.busy, 0);
    chk({tag, "_done"}, req.done, 0);
    chk({tag, "_err"}, req.ack_err, 0);
    chk({tag, "_rd"}, req.rd_data, 0);
  endtask

  initial begin
    int cyc;
    logic [6:0] dv;
    req.start = 1'b0; req.rw = 1'b0; req.dev_addr = '0; req.reg_addr = '0; req.wr_data = '0;
    repeat (3) @(negedge clk);
    check_idle_bus("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle_bus("rst_rel");

    do_txn(1'b0, 7'h3C, 8'h01, 8'hA5, 0);
    do_txn(1'b1, 7'h3C, 8'h00, 8'h00, 0);
    do_txn(1'b0, 7'h3D, 8'h01, 8'h11, 0);
    do_txn(1'b0, 7'h3C, 8'h00, 8'hC3, 1);
    do_txn(1'b1, 7'h3C, 8'h02, 8'h00, 1);

    // Reset asserted in the middle of the register byte (bit 4).
    @(negedge clk);
    req.start = 1'b1; req.rw = 1'b0; req.dev_addr = 7'h3C; req.reg_addr = 8'h01; req.wr_data = 8'h77;
    @(negedge clk);
    req.start = 1'b0;
    cyc = 1;
    for (int g = 0; g < 200 && cyc < 58; g++) begin
      @(negedge clk);
      if (req.busy === 1'b1) cyc++;
    end
    chk("busy_before_rst", req.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_bus("mid_rst");
    rst = 1'b0;
    m_rd = 8'h00;
    repeat (3) @(negedge clk);
    chk("post_rst_sreg1", sregs[1], m_regs[1]);
    do_txn(1'b0, 7'h3C, 8'h01, 8'h03, 0);
    do_txn(1'b1, 7'h3C, 8'h01, 8'h00, 0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    dv = SLV_ADDR;
        2:       dv = 7'h3D;
        default: dv = 7'($urandom_range(0, 127));
      endcase
      do_txn(1'($urandom_range(0, 1)), dv, 8'($urandom_range(0, 2)), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-transaction I2C master that performs one register write or one register read (8-bit register address, 8-bit data) on an open-drain SCL/SDA pair. It is the initiator side of the board's I2C register interface: it drives the same bus that the I2C slave register block responds on, and lets on-chip logic or a board-level tester set and read slave registers such as the LED register at 0x01. It sits in the 100 MHz domain next to the PLL output.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- I2C_FREQ, 100_000, SCL frequency in Hz; quarter-bit divider DIV = CLK_FREQ/(4*I2C_FREQ), must be ≥1
- clk  input  1  system clock; one clock domain, all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- rw  input  1  0 = register write, 1 = register read; captured with start
- dev_addr  input  7  slave address; captured with start
- reg_addr  input  8  register address; captured with start
- wr_data  input  8  write byte; captured with start
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of every transaction, success or failure
- ack_err  output  1  valid with done; 1 = a NACK was sampled at an address or data ack slot
- rd_data  output  8  byte read; updated only on a successful read, held otherwise
- i2c_scl  output  1  open-drain: drives 0 or Z, never 1
- i2c_sda  inout  1  open-drain: drives 0 or Z; sampled directly

## Operation
- Tick: counter produces a one-cycle tick every DIV clocks while busy; counter held at 0 in IDLE.
- Every bit is 4 ticks: ph0 SCL low, update SDA; ph1 release SCL; ph2 SCL high, sample SDA; ph3 pull SCL low.
- START (4 ticks): SDA released with SCL released, then SDA low while SCL high, then SCL low. Repeated START identical.
- STOP (4 ticks): SDA low, release SCL, release SDA while SCL high.
- Bytes MSB first; 8-bit shift register plus 3-bit bit counter; ack slot releases SDA and samples at ph2 (0 = ACK).
- FSM: IDLE → START → ADDR_W → ACK1 → REG → ACK2 → (rw=0) WDATA → ACK3 → STOP → DONE → IDLE; (rw=1) RSTART → ADDR_R → ACK4 → RDATA → MNACK → STOP → DONE → IDLE.
- ADDR_W sends {dev_addr,0}; ADDR_R sends {dev_addr,1}. RDATA releases SDA and shifts in at ph2. MNACK releases SDA (master NACK) for one bit.
- NACK at ACK1/ACK2/ACK3/ACK4: set error flag, go directly to STOP; remaining bytes not sent; rd_data unchanged.
- start while busy is ignored; no queueing. start on the same cycle as done is ignored.
- No clock stretching and no arbitration: SCL is never read back. No bus-busy detection.
- Reset (any time, including mid-byte): SCL and SDA released to Z immediately, FSM to IDLE, busy=0, done=0, ack_err=0, rd_data=0x00, tick counter 0. No STOP is generated; the slave recovers on the next START.

## Timing
- Cycle N: start=1 in IDLE → N+1: busy=1, inputs latched, START ph0 begins.
- Write: 1+27+1 = 29 bit periods = 116 ticks; read: 1+18+1+18+1 = 39 bit periods = 156 ticks. NACK-aborted transaction is shorter by the skipped bits.
- done=1 for exactly one cycle, one clock after the last STOP tick; busy falls in the same cycle done rises. ack_err and rd_data are valid in the done cycle and held until the next start.
- SDA changes only in ph0 (or ph2 for START/STOP edges) so data is stable throughout SCL high.

## Structure
- Package i2c_master_pkg: FSM state enum, phase constants (PH0..PH3), R/W bit constants, DIV computation function.
- Sub-module i2c_tick_gen: parameterised divider with enable and tick output; the rest lives in i2c_master_ctrl.

## Test plan
- Bench uses CLK_FREQ=4_000_000, I2C_FREQ=1_000_000 (DIV=1) and a behavioural slave at 0x3C with a 2-register file; pull-ups modelled on both lines.
- Write: dev 0x3C, reg 0x01, data 0xA5 → bus bytes 0x78,0x01,0xA5 each ACKed, STOP; done after 116 ticks, ack_err=0, slave reg 0x01 = 0xA5.
- Read: preload slave reg 0x00 = 0x5A; rw=1, reg 0x00 → bytes 0x78,0x00, repeated START, 0x79, 0x5A, master NACK, STOP; rd_data=0x5A, ack_err=0, 156 ticks.
- Wrong address 0x3D write → NACK at ACK1, immediate STOP, done with ack_err=1, rd_data unchanged, no write in slave.
- start pulsed again while busy and in the done cycle → ignored; exactly one transaction on the bus, one done pulse.
- Assert rst during REG bit 4 → next cycle SCL=Z, SDA=Z, busy=0, rd_data=0x00; following write 0x01←0x03 completes normally with ack_err=0.
